// File: rtl/ili9341_init_seq.sv
// ILI9341 power-up sequencer: pulses the panel reset, streams the init command
// table to the SPI byte serializer, then forwards RGB565 pixels as byte pairs.
module ili9341_init_seq #(
  parameter int COMM_INIT       = 47,
  parameter int RST_LOW_CYC     = 1000,
  parameter int RST_WAIT_CYC    = 12_000_000,
  parameter int SLPOUT_WAIT_CYC = 12_000_000,
  parameter int CNT_W           = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [$clog2(COMM_INIT)-1:0] cmd_idx,
  input  logic [8:0]                   cmd_entry,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_byte,
  output logic                         tx_dc,
  output logic                         lcd_rst_n,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic [15:0]                  pix_data,
  output logic                         init_done,
  output logic [2:0]                   dbg_state
);

  localparam int IDX_W = $clog2(COMM_INIT);

  localparam logic [2:0] S_RST_LOW  = 3'd0;
  localparam logic [2:0] S_RST_WAIT = 3'd1;
  localparam logic [2:0] S_FETCH    = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_DELAY    = 3'd4;
  localparam logic [2:0] S_IDLE     = 3'd5;
  localparam logic [2:0] S_PIX_HI   = 3'd6;
  localparam logic [2:0] S_PIX_LO   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_dc_q, tx_dc_d;
  logic             lcd_rst_n_q, lcd_rst_n_d;
  logic             pix_ready_q, pix_ready_d;
  logic             init_done_q, init_done_d;
  logic [15:0]      pix_q, pix_d;

  // Both ports are valid/ready: a transfer happens on a cycle where valid and
  // ready are both high; tx_valid/tx_byte/tx_dc never change while unaccepted.
  logic tx_fire, last_idx, needs_delay;
  assign tx_fire     = tx_valid_q & tx_ready;
  assign last_idx    = (idx_q == IDX_W'(COMM_INIT - 1));
  assign needs_delay = !tx_dc_q && ((tx_byte_q == 8'h11) || (tx_byte_q == 8'h29));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;
    tx_dc_d     = tx_dc_q;
    lcd_rst_n_d = lcd_rst_n_q;
    pix_ready_d = pix_ready_q;
    init_done_d = init_done_q;
    pix_d       = pix_q;
    case (state_q)
      S_RST_LOW: begin
        if (cnt_q == CNT_W'(RST_LOW_CYC - 1)) begin
          state_d     = S_RST_WAIT;
          cnt_d       = '0;
          lcd_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == CNT_W'(RST_WAIT_CYC - 1)) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: begin
        tx_byte_d  = cmd_entry[7:0];
        tx_dc_d    = cmd_entry[8];
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          if (needs_delay) begin
            state_d = S_DELAY;
            cnt_d   = '0;
          end else if (last_idx) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
            pix_ready_d = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DELAY: begin
        // Panel needs settling time after Sleep Out / Display On.
        if (cnt_q == CNT_W'(SLPOUT_WAIT_CYC - 1)) begin
          cnt_d = '0;
          if (last_idx) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
            pix_ready_d = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (pix_valid) begin
          pix_d       = pix_data;
          pix_ready_d = 1'b0;
          tx_valid_d  = 1'b1;
          tx_byte_d   = pix_data[15:8];
          tx_dc_d     = 1'b1;
          state_d     = S_PIX_HI;
        end
      end
      S_PIX_HI: begin
        if (tx_fire) begin
          tx_byte_d = pix_q[7:0];
          state_d   = S_PIX_LO;
        end
      end
      S_PIX_LO: begin
        if (tx_fire) begin
          tx_valid_d  = 1'b0;
          pix_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_RST_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RST_LOW;
      cnt_q       <= '0;
      idx_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
      tx_dc_q     <= 1'b0;
      lcd_rst_n_q <= 1'b0;
      pix_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      pix_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      tx_dc_q     <= tx_dc_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      pix_ready_q <= pix_ready_d;
      init_done_q <= init_done_d;
      pix_q       <= pix_d;
    end
  end

  assign cmd_idx   = idx_q;
  assign tx_valid  = tx_valid_q;
  assign tx_byte   = tx_byte_q;
  assign tx_dc     = tx_dc_q;
  assign lcd_rst_n = lcd_rst_n_q;
  assign pix_ready = pix_ready_q;
  assign init_done = init_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ili9341_init_seq.sv
// Directed bench for ili9341_init_seq with shortened delays; all stimulus and
// sampling happen on the falling clock edge.
module tb_ili9341_init_seq;

  logic        clk;
  logic        rst;
  logic [5:0]  cmd_idx;
  logic [8:0]  cmd_entry;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        tx_dc;
  logic        lcd_rst_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        init_done;
  logic [2:0]  dbg_state;

  logic [8:0] tbl [0:46];
  assign cmd_entry = tbl[cmd_idx];

  ili9341_init_seq #(
    .COMM_INIT(47), .RST_LOW_CYC(4), .RST_WAIT_CYC(6),
    .SLPOUT_WAIT_CYC(8), .CNT_W(24)
  ) dut (
    .clk(clk), .rst(rst), .cmd_idx(cmd_idx), .cmd_entry(cmd_entry),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_dc(tx_dc),
    .lcd_rst_n(lcd_rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .init_done(init_done), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stab_err = 0;
  int stall_cnt = 0;
  int early_ready = 0;
  bit bp_en = 0;
  bit held = 0;
  logic [7:0] held_byte;
  logic       held_dc;

  logic [8:0] got_q[$];
  int         hs_cyc[$];
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Driver step: pick tx_ready, log the handshake the next rising edge will
  // perform, then advance to the next falling edge.
  task automatic tick();
    if (bp_en) tx_ready = 1'($urandom_range(0, 1));
    if (!rst) begin
      if (held && (!tx_valid || tx_byte !== held_byte || tx_dc !== held_dc)) stab_err++;
      if (tx_valid && tx_ready) begin
        got_q.push_back({tx_dc, tx_byte});
        hs_cyc.push_back(cyc);
      end
      if (tx_valid && !tx_ready) stall_cnt++;
      if (!init_done && pix_ready) early_ready++;
      held      = tx_valid && !tx_ready;
      held_byte = tx_byte;
      held_dc   = tx_dc;
    end else begin
      held = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_pix(input logic [15:0] d);
    bit acc;
    bit done;
    done = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    for (int k = 0; k < 50; k++) begin
      acc = pix_ready;
      tick();
      if (acc) begin
        done = 1;
        break;
      end
    end
    pix_valid = 1'b0;
    chk("pix_accept", 32'(done), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_idx"},   32'(cmd_idx),   32'd0);
    chk({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
    chk({tag, "_tx_byte"},   32'(tx_byte),   32'd0);
    chk({tag, "_tx_dc"},     32'(tx_dc),     32'd0);
    chk({tag, "_lcd_rst_n"}, 32'(lcd_rst_n), 32'd0);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_state"},     32'(dbg_state), 32'd0);
  endtask

  task automatic wait_init(input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (init_done) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_init_done_seen"}, 32'(seen), 32'd1);
  endtask

  // scoreboard: expected byte stream is the table in index order
  task automatic check_walk(input string tag);
    exp_q.delete();
    for (int i = 0; i < 47; i++) exp_q.push_back(tbl[i]);
    chk({tag, "_count"}, 32'(got_q.size()), 32'd47);
    for (int i = 0; i < 47 && i < got_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int n;
    bit found;
    for (int i = 0; i < 47; i++)
      tbl[i] = (i % 3 != 0) ? {1'b1, 8'(i)} : {1'b0, 8'(192 + i)};
    tbl[0]  = {1'b0, 8'h01};
    tbl[5]  = {1'b0, 8'h11};
    tbl[6]  = {1'b1, 8'h11};
    tbl[30] = {1'b0, 8'h29};

    rst = 1'b1; tx_ready = 1'b1; pix_valid = 1'b0; pix_data = 16'h0000;
    @(negedge clk);

    // Phase 1: reset timing and full walk, pixel offered throughout init
    tick(); tick(); tick();
    check_reset("rst");
    pix_valid = 1'b1;
    pix_data  = 16'hDEAD;
    got_q.delete(); hs_cyc.delete();
    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (lcd_rst_n) begin n = k; break; end
    end
    chk("lcd_rst_low_cycles", 32'(n), 32'd4);
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (tx_valid) begin n = k; break; end
    end
    chk("first_valid_after_rise", 32'(n), 32'd7);
    chk("first_byte", 32'({tx_dc, tx_byte}), 32'(tbl[0]));
    chk("first_idx", 32'(cmd_idx), 32'd0);
    chk("first_state", 32'(dbg_state), 32'd3);
    wait_init("walk");
    pix_valid = 1'b0;
    chk("done_pix_ready", 32'(pix_ready), 32'd1);
    chk("done_cmd_idx", 32'(cmd_idx), 32'd46);
    tick(); tick(); tick();
    chk("idle_state", 32'(dbg_state), 32'd5);
    chk("idle_tx_valid", 32'(tx_valid), 32'd0);
    chk("idle_cmd_idx_hold", 32'(cmd_idx), 32'd46);
    check_walk("walk");
    chk("gap_0_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
    chk("gap_slpout", 32'(hs_cyc[6] - hs_cyc[5]), 32'd10);
    chk("gap_data11", 32'(hs_cyc[7] - hs_cyc[6]), 32'd2);
    chk("gap_dispon", 32'(hs_cyc[31] - hs_cyc[30]), 32'd10);
    chk("gap_last", 32'(hs_cyc[46] - hs_cyc[45]), 32'd2);
    chk("pix_ready_during_init", 32'(early_ready), 32'd0);

    // Phase 2: pixel pass-through
    got_q.delete(); hs_cyc.delete();
    push_pix(16'hF81F);
    push_pix(16'h1234);
    push_pix(16'hABCD);
    for (int k = 0; k < 20 && got_q.size() < 6; k++) tick();
    exp_q.delete();
    exp_q.push_back(9'h1F8); exp_q.push_back(9'h11F);
    exp_q.push_back(9'h112); exp_q.push_back(9'h134);
    exp_q.push_back(9'h1AB); exp_q.push_back(9'h1CD);
    chk("pix_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk($sformatf("pix[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("pix_rate", 32'(hs_cyc[4] - hs_cyc[2]), 32'd3);
    chk("pix_back_idle", 32'(pix_ready), 32'd1);

    // Phase 3: random backpressure replays the same sequence
    rst = 1'b1;
    tick(); tick();
    got_q.delete(); hs_cyc.delete();
    stab_err = 0; stall_cnt = 0;
    bp_en = 1;
    rst = 1'b0;
    wait_init("bp");
    bp_en = 0;
    tx_ready = 1'b1;
    check_walk("bp_walk");
    chk("bp_stable", 32'(stab_err), 32'd0);
    chk("bp_exercised", 32'(stall_cnt > 0), 32'd1);

    // Phase 4: reset while index 20 is stalled in SEND
    rst = 1'b1;
    tick(); tick();
    got_q.delete(); hs_cyc.delete();
    rst = 1'b0;
    found = 0;
    for (int k = 0; k < 2000; k++) begin
      if (tx_valid && cmd_idx == 6'd20) begin found = 1; break; end
      tick();
    end
    chk("mid_reach_idx20", 32'(found), 32'd1);
    chk("mid_sent_before", 32'(got_q.size()), 32'd20);
    tx_ready = 1'b0;
    tick(); tick();
    chk("mid_stall_valid", 32'(tx_valid), 32'd1);
    chk("mid_stall_byte", 32'({tx_dc, tx_byte}), 32'(tbl[20]));
    chk("mid_stall_state", 32'(dbg_state), 32'd3);
    rst = 1'b1;
    tick();
    check_reset("mid_rst");
    got_q.delete(); hs_cyc.delete();
    rst = 1'b0;
    tx_ready = 1'b1;
    wait_init("replay");
    check_walk("replay_walk");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
